// File: rtl/psum_accum_buf_pkg.sv
// Shared types and helpers for the partial-sum accumulator buffer.
// Holds the FSM state encoding and the lane sign-extension helper.
package neurex_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } acc_state_e;

  localparam int ACC_WIDTH_DEF = 32;

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] sext64(
    input logic [63:0] v,
    input int unsigned w
  );
    sext64 = 64'($signed(v << (64 - w)) >>> (64 - w));
  endfunction

endpackage

// File: rtl/psum_accum_buf_lane.sv
// One accumulator lane: sign-extend, then overwrite or add.
// With PSUM_ACCUM_SAT_EN the result clamps to the signed AW range.
module psum_acc_lane
  import neurex_acc_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = ACC_WIDTH_DEF
) (
  input  logic          first_i,
  input  logic [DW-1:0] psum_i,
  input  logic [AW-1:0] acc_i,
  output logic [AW-1:0] res_o
`ifdef PSUM_ACCUM_SAT_EN
  ,
  output logic          sat_o
`endif
);

`ifdef PSUM_ACCUM_SAT_EN
  logic [AW:0] ext;
  logic [AW:0] sum;
  logic        ovf;

  assign ext = (AW+1)'(sext64(64'(psum_i), DW));
  assign sum = first_i ? ext : {acc_i[AW-1], acc_i} + ext;
  // Guard bit disagreeing with the sign bit means the sum left range.
  assign ovf = sum[AW] ^ sum[AW-1];
  assign sat_o = ovf;
  assign res_o = !ovf    ? sum[AW-1:0] :
                 sum[AW] ? {1'b1, {(AW-1){1'b0}}} :
                           {1'b0, {(AW-1){1'b1}}};
`else
  logic [AW-1:0] ext;

  assign ext = AW'(sext64(64'(psum_i), DW));
  assign res_o = first_i ? ext : acc_i + ext;
`endif

endmodule

// File: rtl/psum_accum_buf.sv
// Partial-sum accumulator buffer: per-pass overwrite/accumulate, then drain.
// Define PSUM_ACCUM_SAT_EN for saturating lanes and the sat_flag output.
module psum_accum_buf
  import neurex_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int ADDR_WIDTH = 16,
  parameter int SYS_COL    = 16,
  parameter int ACC_DEPTH  = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          acc_en,
  input  logic                          first_pass,
  input  logic                          last_pass,
  input  logic [ADDR_WIDTH-1:0]         num_row,
  input  logic                          psum_valid,
  input  logic [ADDR_WIDTH-1:0]         psum_addr,
  input  logic [SYS_COL*DATA_WIDTH-1:0] psum_in,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [SYS_COL*ACC_WIDTH-1:0]  out_data,
  output logic                          pass_done,
  output logic                          drain_done,
  output logic                          busy,
  output logic                          addr_err
`ifdef PSUM_ACCUM_SAT_EN
  ,
  output logic                          sat_flag
`endif
);

  localparam int RW = SYS_COL * ACC_WIDTH;
  localparam int IW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(ACC_DEPTH);

  acc_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] nrow_q, nrow_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  pass_done_q, pass_done_d;
  logic                  drain_done_q, drain_done_d;
  logic                  addr_err_q, addr_err_d;

  logic [RW-1:0]         mem_q [ACC_DEPTH];
  logic [RW-1:0]         acc_row;
  logic [RW-1:0]         row_new;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic                  wr_hit;
  logic                  wr_en;
  logic                  hs;

  assign wr_idx  = psum_addr[IW-1:0];
  assign rd_idx  = rd_ptr_q[IW-1:0];
  assign acc_row = mem_q[wr_idx];
  assign wr_hit  = (state_q == ACCUM) && psum_valid;
  // nrow never exceeds the depth, so this also drops out-of-range rows.
  assign wr_en   = wr_hit && (psum_addr < nrow_q);
  assign cnt_inc = wr_cnt_q + ADDR_WIDTH'(psum_valid);
  assign hs      = out_valid && out_ready;

`ifdef PSUM_ACCUM_SAT_EN
  logic [SYS_COL-1:0] sat_l;
  logic               sat_q, sat_d;
`endif

  for (genvar g = 0; g < SYS_COL; g++) begin : g_lane
    psum_acc_lane #(
      .DW(DATA_WIDTH),
      .AW(ACC_WIDTH)
    ) u_lane (
      .first_i(first_q),
      .psum_i (psum_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .acc_i  (acc_row[g*ACC_WIDTH +: ACC_WIDTH]),
      .res_o  (row_new[g*ACC_WIDTH +: ACC_WIDTH])
`ifdef PSUM_ACCUM_SAT_EN
      ,
      .sat_o  (sat_l[g])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < ACC_DEPTH; r++) mem_q[r] <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= row_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      nrow_q       <= '0;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      pass_done_q  <= 1'b0;
      drain_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      nrow_q       <= nrow_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      first_q      <= first_d;
      last_q       <= last_d;
      pass_done_q  <= pass_done_d;
      drain_done_q <= drain_done_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nrow_d       = nrow_q;
    wr_cnt_d     = wr_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    first_d      = first_q;
    last_d       = last_q;
    pass_done_d  = 1'b0;
    drain_done_d = 1'b0;
    addr_err_d   = addr_err_q | (wr_hit && (psum_addr >= DEPTH_A));
    unique case (state_q)
      IDLE: begin
        if (acc_en) begin
          state_d  = ACCUM;
          first_d  = first_pass;
          last_d   = last_pass;
          nrow_d   = (num_row > DEPTH_A) ? DEPTH_A : num_row;
          wr_cnt_d = '0;
          rd_ptr_d = '0;
        end
      end
      ACCUM: begin
        wr_cnt_d = cnt_inc;
        if (cnt_inc >= nrow_q) begin
          pass_done_d = 1'b1;
          state_d     = last_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (nrow_q == '0) begin
          drain_done_d = 1'b1;
          state_d      = IDLE;
        end else if (hs) begin
          if (rd_ptr_q == nrow_q - ADDR_WIDTH'(1)) begin
            drain_done_d = 1'b1;
            state_d      = IDLE;
            rd_ptr_d     = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PSUM_ACCUM_SAT_EN
  assign sat_d = sat_q | (wr_en && (|sat_l));

  always_ff @(posedge clk) begin
    if (!rstn) sat_q <= 1'b0;
    else       sat_q <= sat_d;
  end

  assign sat_flag = sat_q;
`endif

  assign out_valid  = (state_q == DRAIN) && (nrow_q != '0);
  assign out_addr   = rd_ptr_q;
  assign out_data   = mem_q[rd_idx];
  assign pass_done  = pass_done_q;
  assign drain_done = drain_done_q;
  assign busy       = (state_q != IDLE);
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_psum_accum_buf.sv
// Randomized bench for psum_accum_buf against a per-row/per-lane array model.
// Builds with or without PSUM_ACCUM_SAT_EN.
module tb_psum_accum_buf;

  localparam int DW  = 24;
  localparam int AW  = 32;
  localparam int ADW = 16;
  localparam int SC  = 4;
  localparam int AD  = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic acc_en = 1'b0;
  logic first_pass = 1'b0;
  logic last_pass = 1'b0;
  logic psum_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [ADW-1:0] num_row = '0;
  logic [ADW-1:0] psum_addr = '0;
  logic [SC*DW-1:0] psum_in = '0;
  logic out_valid, pass_done, drain_done, busy, addr_err;
  logic [ADW-1:0] out_addr;
  logic [SC*AW-1:0] out_data;
`ifdef PSUM_ACCUM_SAT_EN
  logic sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] mdl [AD][SC];
  bit exp_err;
  bit exp_sat;

  typedef struct {
    logic [ADW-1:0]   addr;
    logic [SC*DW-1:0] data;
    bit               gap;
  } wr_t;
  wr_t wq[$];

  psum_accum_buf #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .ADDR_WIDTH(ADW),
    .SYS_COL   (SC),
    .ACC_DEPTH (AD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .acc_en    (acc_en),
    .first_pass(first_pass),
    .last_pass (last_pass),
    .num_row   (num_row),
    .psum_valid(psum_valid),
    .psum_addr (psum_addr),
    .psum_in   (psum_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .pass_done (pass_done),
    .drain_done(drain_done),
    .busy      (busy),
    .addr_err  (addr_err)
`ifdef PSUM_ACCUM_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  function automatic void mdl_clear();
    for (int r = 0; r < AD; r++)
      for (int l = 0; l < SC; l++) mdl[r][l] = '0;
    exp_err = 1'b0;
    exp_sat = 1'b0;
  endfunction

  function automatic void mdl_write(input bit first, input int nrow,
                                    input logic [ADW-1:0] addr,
                                    input logic [SC*DW-1:0] d);
    longint v, s;
    longint lim;
    lim = longint'(1) << (AW - 1);
    if (int'(addr) >= AD) begin
      exp_err = 1'b1;
      return;
    end
    if (int'(addr) >= nrow) return;
    for (int l = 0; l < SC; l++) begin
      v = longint'($signed(d[l*DW +: DW]));
      s = first ? v : longint'($signed(mdl[addr][l])) + v;
`ifdef PSUM_ACCUM_SAT_EN
      if (s > lim - 1) begin
        s = lim - 1;
        exp_sat = 1'b1;
      end else if (s < -lim) begin
        s = -lim;
        exp_sat = 1'b1;
      end
`endif
      mdl[addr][l] = s[AW-1:0];
    end
  endfunction

  function automatic logic [SC*AW-1:0] mdl_row(input int r);
    logic [SC*AW-1:0] v;
    for (int l = 0; l < SC; l++) v[l*AW +: AW] = mdl[r][l];
    return v;
  endfunction

  function automatic logic [SC*DW-1:0] lanes_rand();
    logic [SC*DW-1:0] v;
    for (int l = 0; l < SC; l++) v[l*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [SC*DW-1:0] lanes_small();
    logic [SC*DW-1:0] v;
    for (int l = 0; l < SC; l++)
      v[l*DW +: DW] = DW'($urandom_range(0, 2000)) - DW'(1000);
    return v;
  endfunction

  function automatic void push_wr(input logic [ADW-1:0] a,
                                  input logic [SC*DW-1:0] d, input bit gap);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.gap  = gap;
    wq.push_back(w);
  endfunction

  task automatic drain(input int n, input int mode, input int stop);
    int r = 0;
    int cyc = 0;
    bit rdy;
    bit done = 1'b0;
    logic [3:0] pat = 4'b1001;
    while (!done && cyc < 8 * n + 20) begin
      if (r == stop) begin
        out_ready = 1'b0;
        acc_en = 1'b0;
        return;
      end
      checks++;
      if (out_valid !== 1'b1 || out_addr !== ADW'(r) ||
          out_data !== mdl_row(r) || drain_done !== 1'b0) begin
        errors++;
        $display("FAIL drain_row r=%0d valid=%b addr=%0d data=%h dd=%b want valid=1 addr=%0d data=%h dd=0",
                 r, out_valid, out_addr, out_data, drain_done, r, mdl_row(r));
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      acc_en = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        r++;
        done = (r == n);
      end
    end
    out_ready = 1'b0;
    acc_en = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout rows=%0d want %0d", r, n);
    end
    checks++;
    if (drain_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_done dd=%b valid=%b want dd=1 valid=0", drain_done, out_valid);
    end
    @(negedge clk);
    checks++;
    if (drain_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle dd=%b busy=%b want 0 0", drain_done, busy);
    end
  endtask

  task automatic do_pass(input bit first, input bit last, input int nr,
                         input int mode, input int stop);
    int eff;
    wr_t w;
    eff = (nr > AD) ? AD : nr;
    @(negedge clk);
    acc_en = 1'b1;
    first_pass = first;
    last_pass = last;
    num_row = ADW'(nr);
    @(negedge clk);
    acc_en = 1'b0;
    checks++;
    if (busy !== 1'b1 || pass_done !== 1'b0) begin
      errors++;
      $display("FAIL pass_start busy=%b pd=%b want 1 0", busy, pass_done);
    end
    while (wq.size() > 0) begin
      w = wq.pop_front();
      if (w.gap) begin
        psum_valid = 1'b0;
        acc_en = 1'b1;
        first_pass = ~first;
        @(negedge clk);
        acc_en = 1'b0;
        first_pass = first;
        checks++;
        if (pass_done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL pass_gap pd=%b busy=%b want 0 1", pass_done, busy);
        end
      end
      psum_valid = 1'b1;
      psum_addr = w.addr;
      psum_in = w.data;
      mdl_write(first, eff, w.addr, w.data);
      @(negedge clk);
      psum_valid = 1'b0;
      if (wq.size() > 0) begin
        checks++;
        if (pass_done !== 1'b0) begin
          errors++;
          $display("FAIL pass_early pd=%b want 0", pass_done);
        end
      end
    end
    checks++;
    if (pass_done !== 1'b1 || busy !== last || addr_err !== exp_err) begin
      errors++;
      $display("FAIL pass_done pd=%b busy=%b err=%b want 1 %b %b",
               pass_done, busy, addr_err, last, exp_err);
    end
`ifdef PSUM_ACCUM_SAT_EN
    checks++;
    if (sat_flag !== exp_sat) begin
      errors++;
      $display("FAIL sat_flag got %b want %b", sat_flag, exp_sat);
    end
`endif
    if (last) begin
      drain(eff, mode, stop);
    end else begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || drain_done !== 1'b0 ||
          busy !== 1'b0 || pass_done !== 1'b0) begin
        errors++;
        $display("FAIL no_drain valid=%b dd=%b busy=%b pd=%b want 0 0 0 0",
                 out_valid, drain_done, busy, pass_done);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, pass_done, drain_done, busy, addr_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {out_valid, pass_done, drain_done, busy, addr_err});
    end
    checks++;
    if (out_addr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%0d data=%h want 0", out_addr, out_data);
    end
`ifdef PSUM_ACCUM_SAT_EN
    checks++;
    if (sat_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat got %b want 0", sat_flag);
    end
`endif
    rstn = 1'b1;
    mdl_clear();
  endtask

  task automatic test_single_pass();
    logic [SC*DW-1:0] d;
    for (int r = 0; r < 4; r++) begin
      for (int l = 0; l < SC; l++) d[l*DW +: DW] = DW'(r * 16 + l);
      push_wr(ADW'(r), d, 1'b0);
    end
    do_pass(1'b1, 1'b1, 4, 0, -1);
  endtask

  task automatic test_two_pass();
    logic [SC*DW-1:0] d;
    for (int l = 0; l < SC; l++) d[l*DW +: DW] = DW'(5);
    push_wr(ADW'(0), d, 1'b0);
    push_wr(ADW'(1), d, 1'b0);
    do_pass(1'b1, 1'b0, 2, 0, -1);
    for (int l = 0; l < SC; l++) d[l*DW +: DW] = DW'(-3);
    push_wr(ADW'(1), d, 1'b0);
    push_wr(ADW'(0), d, 1'b0);
    do_pass(1'b0, 1'b1, 2, 0, -1);
  endtask

  task automatic test_backpressure();
    for (int r = 0; r < 4; r++) push_wr(ADW'(r), lanes_rand(), 1'b0);
    do_pass(1'b1, 1'b1, 4, 1, -1);
  endtask

  task automatic test_nrow_zero();
    @(negedge clk);
    acc_en = 1'b1;
    first_pass = 1'b1;
    last_pass = 1'b1;
    num_row = '0;
    @(negedge clk);
    acc_en = 1'b0;
    psum_valid = 1'b1;
    psum_addr = '0;
    psum_in = lanes_rand();
    mdl_write(1'b1, 0, psum_addr, psum_in);
    checks++;
    if (pass_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_entry pd=%b busy=%b want 0 1", pass_done, busy);
    end
    @(negedge clk);
    psum_valid = 1'b0;
    checks++;
    if (pass_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_pass pd=%b valid=%b want 1 0", pass_done, out_valid);
    end
    @(negedge clk);
    checks++;
    if (drain_done !== 1'b1 || out_valid !== 1'b0 || pass_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_drain dd=%b valid=%b pd=%b want 1 0 0",
               drain_done, out_valid, pass_done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle busy=%b dd=%b want 0 0", busy, drain_done);
    end
  endtask

  task automatic test_addr_err();
    for (int r = 0; r < 3; r++) push_wr(ADW'(r), lanes_rand(), 1'b0);
    do_pass(1'b1, 1'b0, 3, 0, -1);
    push_wr(ADW'(0), lanes_rand(), 1'b0);
    push_wr(ADW'(AD), lanes_rand(), 1'b0);
    push_wr(ADW'(1), lanes_rand(), 1'b0);
    do_pass(1'b0, 1'b1, 3, 0, -1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 6; p++) begin
      int nr, eff;
      bit f, l;
      nr = $urandom_range(1, 12);
      eff = (nr > AD) ? AD : nr;
      f = (p == 0) || ($urandom_range(0, 1) == 1);
      l = (p == 5) || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      psum_valid = 1'b1;
      psum_addr = ADW'($urandom_range(0, AD - 1));
      psum_in = lanes_rand();
      @(negedge clk);
      psum_valid = 1'b0;
      for (int i = 0; i < eff; i++)
        push_wr(ADW'($urandom_range(0, eff - 1)), lanes_rand(),
                $urandom_range(0, 3) == 0);
      do_pass(f, l, nr, 2, -1);
    end
  endtask

  task automatic test_wrap();
    logic [SC*DW-1:0] d;
    for (int p = 0; p < 32; p++) begin
      for (int i = 0; i < AD; i++) begin
        d = lanes_small();
        d[0 +: DW] = 24'h7FFFFF;
        d[DW +: DW] = 24'h800000;
        push_wr(ADW'(0), d, 1'b0);
      end
      do_pass(p == 0, 1'b0, AD, 0, -1);
    end
    d = lanes_small();
    d[0 +: DW] = DW'(255);
    d[DW +: DW] = '0;
    push_wr(ADW'(0), d, 1'b0);
    do_pass(1'b0, 1'b1, 1, 0, -1);
    d = lanes_small();
    d[0 +: DW] = DW'(1);
    d[DW +: DW] = {DW{1'b1}};
    push_wr(ADW'(0), d, 1'b0);
    do_pass(1'b0, 1'b1, 1, 0, -1);
  endtask

  task automatic test_reset_mid_drain();
    for (int r = 0; r < 4; r++) push_wr(ADW'(r), lanes_rand(), 1'b0);
    do_pass(1'b1, 1'b1, 4, 0, 2);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || drain_done !== 1'b0 ||
        pass_done !== 1'b0 || addr_err !== 1'b0 || out_addr !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b valid=%b dd=%b pd=%b err=%b addr=%0d want all 0",
               busy, out_valid, drain_done, pass_done, addr_err, out_addr);
    end
    rstn = 1'b1;
    mdl_clear();
    @(negedge clk);
    checks++;
    if (drain_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle dd=%b busy=%b want 0 0", drain_done, busy);
    end
    for (int r = 0; r < AD; r++) push_wr(ADW'(r), '0, 1'b0);
    do_pass(1'b0, 1'b1, AD, 0, -1);
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_two_pass();
    test_backpressure();
    test_nrow_zero();
    test_addr_err();
    test_random();
    test_wrap();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
